// File: rtl/alu_arb_pkg.sv
// Shared opcode encodings, request record and opcode legality check for the ALU arbiter.
// Optional build macro used by alu_arbiter: ALU_ARB_FLAGS_EN.
package alu_arb_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_INC = 4'b0010;
    localparam logic [3:0] OP_DEC = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_AND = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;

    // Wide enough for the largest supported requester count (8).
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic [3:0]          op;
        logic [31:0]         a;
        logic [31:0]         b;
        logic [MAX_ID_W-1:0] id;
    } alu_req_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_NOP, OP_INC, OP_DEC, OP_ADD, OP_SUB,
            OP_OR, OP_AND, OP_XOR, OP_NOT: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo N.
// The caller owns the pointer register.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    int            w_pos;
    logic [IW-1:0] w_idx;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_pos   = 0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= N) w_pos = w_pos - N;
            w_idx = IW'(w_pos);
            if (!gnt_any && req[w_idx]) begin
                gnt_any        = 1'b1;
                gnt_idx        = w_idx;
                grant[w_idx]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external ALU: S1 issue register drives alu_*, S2 holds the response.
// Build macro ALU_ARB_FLAGS_EN adds registered rsp_zero / rsp_neg outputs.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*4-1:0]  req_op,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [3:0]            alu_opcode,
    input  logic [31:0]           alu_res,
`ifdef ALU_ARB_FLAGS_EN
    output logic                  rsp_zero,
    output logic                  rsp_neg,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err
);

    logic [ID_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_gnt_any;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic               w_s1_load;
    logic               w_s2_load;
    logic               w_sel_legal;
    alu_req_t           w_sel;

    logic               r_s1_valid;
    logic               r_s1_err;
    logic [ID_W-1:0]    r_s1_id;
    logic [31:0]        r_alu_a;
    logic [31:0]        r_alu_b;
    logic [3:0]         r_alu_op;

    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_err;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (r_ptr),
        .grant   (w_grant),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    always_comb begin
        w_sel.op = req_op[4*w_gnt_idx +: 4];
        w_sel.a  = req_a[32*w_gnt_idx +: 32];
        w_sel.b  = req_b[32*w_gnt_idx +: 32];
        w_sel.id = MAX_ID_W'(w_gnt_idx);
    end

    assign w_sel_legal = is_legal_op(w_sel.op);
    assign w_s2_load   = r_s1_valid && (!r_rsp_valid || rsp_ready);
    assign w_s1_load   = w_gnt_any && (!r_s1_valid || w_s2_load);
    assign w_ptr_nxt   = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign req_ready   = w_s1_load ? w_grant : '0;

    // S1: illegal opcodes still issue, but as a nop so the ALU never sees them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_id    <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= OP_NOP;
        end else if (w_s1_load) begin
            r_ptr      <= w_ptr_nxt;
            r_s1_valid <= 1'b1;
            r_s1_err   <= !w_sel_legal;
            r_s1_id    <= ID_W'(w_sel.id);
            r_alu_a    <= w_sel.a;
            r_alu_b    <= w_sel.b;
            r_alu_op   <= w_sel_legal ? w_sel.op : OP_NOP;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_s1_id;
            r_rsp_data  <= r_s1_err ? '0 : alu_res;
            r_rsp_err   <= r_s1_err;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    logic r_rsp_zero;
    logic r_rsp_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_zero <= 1'b0;
            r_rsp_neg  <= 1'b0;
        end else if (w_s2_load) begin
            r_rsp_zero <= !r_s1_err && (alu_res == 32'd0);
            r_rsp_neg  <= !r_s1_err && alu_res[31];
        end
    end

    assign rsp_zero = r_rsp_zero;
    assign rsp_neg  = r_rsp_neg;
`endif

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, hand sequences, and a randomized stream
// checked against a queue-based reference model. Flag checks compile in with ALU_ARB_FLAGS_EN.
module tb_alu_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*4-1:0]  req_op;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [31:0]     alu_a, alu_b, alu_res;
    logic [3:0]      alu_opcode;
    logic            rsp_valid, rsp_ready, rsp_err;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_data;
`ifdef ALU_ARB_FLAGS_EN
    logic            rsp_zero, rsp_neg;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_res    (alu_res),
`ifdef ALU_ARB_FLAGS_EN
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    // Stand-in for the external ALU; nop passes operand A through.
    function automatic logic [31:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'h0:    return a;
            4'h2:    return a + 32'd1;
            4'h3:    return a - 32'd1;
            4'h4:    return a + b;
            4'h5:    return a - b;
            4'h8:    return a | b;
            4'h9:    return a & b;
            4'hA:    return a ^ b;
            4'hB:    return ~a;
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_res = alu_fn(alu_opcode, alu_a, alu_b);

    function automatic bit legal(logic [3:0] op);
        return op inside {4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
        int          t;
    } exp_t;

    typedef struct {
        int          rid;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        err;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        q[$];
    int          gnt_log[$];
    int          m_ptr = 0;
    bit          mon_en = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_a, prev_b;
    logic [3:0]  prev_op;
    vec_t        tbl[14];

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model step, evaluated at every falling edge from the pipeline's point of view:
    // at most two ops in flight, the oldest is visible two edges after it was accepted.
    task automatic mon_step();
        logic [N-1:0] exp_ready;
        logic [N-1:0] hs;
        int           g;
        bit           exp_rv;
        bit           stall_now;
        exp_t         e;
        if (!mon_en || !rst_n) return;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (g < 0 && req_valid[i]) g = i;
        end
        exp_ready = '0;
        if (g >= 0 && (q.size() < 2 || rsp_ready)) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        exp_rv = (q.size() > 0) && (cyc - q[0].t >= 2);
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (prev_stall) begin
            chk("stall_alu_a", alu_a, prev_a);
            chk("stall_alu_b", alu_b, prev_b);
            chk("stall_alu_op", 32'(alu_opcode), 32'(prev_op));
        end
        stall_now  = (q.size() == 2) && !rsp_ready;
        prev_stall = stall_now;
        prev_a     = alu_a;
        prev_b     = alu_b;
        prev_op    = alu_opcode;
        if (rsp_valid && exp_rv) begin
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
`ifdef ALU_ARB_FLAGS_EN
            chk("rsp_zero", 32'(rsp_zero), 32'(!q[0].err && q[0].data == 32'd0));
            chk("rsp_neg", 32'(rsp_neg), 32'(!q[0].err && q[0].data[31]));
`endif
            if (rsp_ready) e = q.pop_front();
        end
        hs = req_valid & req_ready;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                e.id   = i;
                e.err  = !legal(req_op[4*i +: 4]);
                e.data = e.err ? 32'd0 : alu_fn(req_op[4*i +: 4], req_a[32*i +: 32], req_b[32*i +: 32]);
                e.t    = cyc;
                q.push_back(e);
                gnt_log.push_back(i);
                m_ptr = (i + 1) % N;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(int i);
        req_op[4*i +: 4]   = 4'($urandom_range(0, 15));
        req_a[32*i +: 32]  = $urandom;
        req_b[32*i +: 32]  = $urandom;
    endtask

    // Requesters refresh only after acceptance (or when idle), so held requests stay stable.
    task automatic run(int n, int p_valid, int p_ready);
        logic [N-1:0] acc;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < p_valid);
                    new_req(i);
                end
            end
            rsp_ready = ($urandom_range(0, 99) < p_ready);
        end
    endtask

    task automatic drain();
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0) break;
        end
        chk("drain_empty", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic run_vector(vec_t v);
        bit ok;
        int lat;
        step();
        req_valid                = '0;
        req_valid[v.rid]         = 1'b1;
        req_op[4*v.rid +: 4]     = v.op;
        req_a[32*v.rid +: 32]    = v.a;
        req_b[32*v.rid +: 32]    = v.b;
        rsp_ready                = 1'b1;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[v.rid]) begin ok = 1; break; end
        end
        chk("tbl_accept", 32'(ok), 32'd1);
        step();
        req_valid = '0;
        ok  = 0;
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin ok = 1; break; end
        end
        chk("tbl_rsp_seen", 32'(ok), 32'd1);
        chk("tbl_latency", lat, 2);
        chk("tbl_id", 32'(rsp_id), v.rid);
        chk("tbl_data", rsp_data, v.data);
        chk("tbl_err", 32'(rsp_err), 32'(v.err));
`ifdef ALU_ARB_FLAGS_EN
        chk("tbl_zero", 32'(rsp_zero), 32'(!v.err && v.data == 32'd0));
        chk("tbl_neg", 32'(rsp_neg), 32'(!v.err && v.data[31]));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int start;
        int p0;
        tbl[0]  = '{2, 4'b0100, 32'd5,          32'd7,          32'd12,         1'b0};
        tbl[1]  = '{1, 4'b0111, 32'd1,          32'd1,          32'd0,          1'b1};
        tbl[2]  = '{0, 4'b0101, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
        tbl[3]  = '{3, 4'b0010, 32'hFFFF_FFFF,  32'd0,          32'd0,          1'b0};
        tbl[4]  = '{1, 4'b0011, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0};
        tbl[5]  = '{2, 4'b1000, 32'hF0F0_0000,  32'h0000_0F0F,  32'hF0F0_0F0F,  1'b0};
        tbl[6]  = '{0, 4'b1001, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  1'b0};
        tbl[7]  = '{3, 4'b1010, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,  1'b0};
        tbl[8]  = '{2, 4'b1011, 32'h1234_5678,  32'd99,         32'hEDCB_A987,  1'b0};
        tbl[9]  = '{1, 4'b1111, 32'd7,          32'd9,          32'd0,          1'b1};
        tbl[10] = '{0, 4'b0000, 32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF,  1'b0};
        tbl[11] = '{3, 4'b0001, 32'd5,          32'd5,          32'd0,          1'b1};
        tbl[12] = '{0, 4'b0101, 32'd9,          32'd9,          32'd0,          1'b0};
        tbl[13] = '{1, 4'b0100, 32'h8000_0000,  32'h8000_0000,  32'd0,          1'b0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", 32'(alu_opcode), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
`ifdef ALU_ARB_FLAGS_EN
        chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("rst_rsp_neg", 32'(rsp_neg), 32'd0);
`endif
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        foreach (tbl[i]) run_vector(tbl[i]);
        drain();

        // Continuous contention: grants must rotate strictly from the current pointer.
        step();
        for (int i = 0; i < N; i++) new_req(i);
        req_valid = '1;
        rsp_ready = 1'b1;
        start = gnt_log.size();
        p0    = m_ptr;
        run(12, 100, 100);
        chk("rr_count", 32'(gnt_log.size() >= start + 12), 32'd1);
        for (int k = 0; k < 12; k++) begin
            if (start + k < gnt_log.size())
                chk("rr_order", gnt_log[start + k], (p0 + k) % N);
        end

        // Backpressure for five cycles mid-stream.
        run(3, 100, 100);
        run(5, 100, 0);
        @(negedge clk);
        chk("bp_ready_zero", 32'(req_ready), 32'd0);
        chk("bp_rsp_hold", 32'(rsp_valid), 32'd1);
        run(10, 100, 100);
        drain();

        run(400, 50, 70);
        drain();

        // Reset while both stages are full.
        step();
        for (int i = 0; i < N; i++) new_req(i);
        req_valid = '1;
        run(4, 100, 0);
        @(negedge clk);
        chk("rst_pre_full", 32'(rsp_valid), 32'd1);
        #2;
        mon_en    = 1'b0;
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_alu_op", 32'(alu_opcode), 32'd0);
        chk("rst_mid_alu_a", alu_a, 32'd0);
        q.delete();
        m_ptr      = 0;
        prev_stall = 0;
        step();
        step();
        rst_n = 1'b1;
        req_valid           = 4'b1010;
        req_op[4*1 +: 4]    = 4'b0100;
        req_a[32*1 +: 32]   = 32'd1;
        req_b[32*1 +: 32]   = 32'd2;
        req_op[4*3 +: 4]    = 4'b0101;
        req_a[32*3 +: 32]   = 32'd10;
        req_b[32*3 +: 32]   = 32'd4;
        rsp_ready = 1'b1;
        mon_en    = 1'b1;
        start     = gnt_log.size();
        @(negedge clk);
        chk("rst_first_grant", 32'(req_ready), 32'b0010);
        run(6, 0, 100);
        chk("rst_grant_count", 32'(gnt_log.size() >= start + 2), 32'd1);
        if (gnt_log.size() >= start + 2) begin
            chk("rst_grant0", gnt_log[start], 1);
            chk("rst_grant1", gnt_log[start + 1], 3);
        end
        drain();

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between NUM_REQ requesters using round-robin arbitration.
- Each requester uses valid/ready handshakes. The block registers the granted operands and drives them to the ALU, then registers the ALU result into a response stage that carries the requester ID.
- Sits between decode/issue units and the single ALU instance. The ALU stays outside this block and connects through the alu_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester ID (derived; do not override).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_op  in  NUM_REQ*4  flattened opcodes; requester i at [4i+3:4i].
- req_a  in  NUM_REQ*32  flattened operand A.
- req_b  in  NUM_REQ*32  flattened operand B.
- alu_a  out  32  registered operand A to the ALU.
- alu_b  out  32  registered operand B to the ALU.
- alu_opcode  out  4  registered opcode to the ALU.
- alu_res  in  32  combinational ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the originating requester.
- rsp_data  out  32  result.
- rsp_err  out  1  illegal opcode flag.

Behaviour:
- Reset values: req_ready=0, alu_a=0, alu_b=0, alu_opcode=4'b0000 (nop), rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, RR pointer=0, s1_valid=0.
- Pipeline: S1 (issue register driving alu_*) -> S2 (response register).
- s2_load = s1_valid && (!rsp_valid || rsp_ready).
- s1_load = any req_valid && (!s1_valid || s2_load).
- Throughput is 1 op/cycle. Latency is 2 cycles from the accepting edge (req_valid && req_ready) to rsp_valid=1.
- Arbitration: combinational round-robin. Search starts at ptr and wraps modulo NUM_REQ. The first requester with req_valid set is granted.
- req_ready[grant]=1 only when s1_load=1. At most one req_ready bit is high per cycle.
- On accept, ptr <= grant+1 (wraps from NUM_REQ-1 to 0). Without an accept, ptr holds.
- Requesters hold req_valid, op, a and b stable until accepted. A requester never sees req_ready without req_valid.
- Legal opcodes: 0000, 0010, 0011, 0100, 0101, 1000, 1001, 1010, 1011.
- An illegal opcode is still accepted. S1 drives alu_opcode=0000 with operands unchanged. S2 sets rsp_data=0 and rsp_err=1.
- S1 holds alu_a, alu_b and alu_opcode stable while stalled. The ALU output therefore stays stable.
- Backpressure: rsp_valid && !rsp_ready holds S2, then S1 fills, then req_ready goes to 0 for all requesters. No response is ever dropped or duplicated.
- When S2 drains and S1 refills in the same cycle, throughput stays uninterrupted.
- Simultaneous requests: strict rotation. Under continuous contention, no requester waits more than NUM_REQ-1 accepts.
- Reset mid-operation: all in-flight ops are discarded, rsp_valid drops asynchronously, and ptr returns to 0.
- Arithmetic (32-bit wrap, carries) belongs to the ALU. This block passes results through unmodified.

Optional Feature:
- Macro: ALU_ARB_FLAGS_EN.
- When defined:
  - Adds outputs rsp_zero (1) and rsp_neg (1), registered in S2 alongside rsp_data.
  - rsp_zero = (alu_res==0).
  - rsp_neg = alu_res[31].
  - Both flags reset to 0 and are forced to 0 when rsp_err=1.
- When undefined: the ports and logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Package alu_arb_pkg holds:
  - opcode localparams (OP_NOP, OP_INC, OP_DEC, OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_NOT);
  - function is_legal_op(logic [3:0]);
  - typedef alu_req_t {op, a, b, id}.
- Sub-module rr_arbiter (params N; ports req, ptr, grant one-hot, gnt_idx, gnt_any).
  - Combinational; reused elsewhere.
  - The pointer register stays in alu_arbiter.

Test Plan:
- Single request: req 2 sends op=0100, a=5, b=7 -> req_ready[2] for one cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_data=12, rsp_err=0.
- All 4 requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,1…; one response per cycle; IDs follow the same order.
- Backpressure: rsp_ready=0 for 5 cycles during a stream -> rsp fields stable, all req_ready=0 after S1 fills; on release, no loss or duplication (check the ID/data sequence).
- Illegal op 0111, a=1, b=1 -> rsp_err=1, rsp_data=0; the next legal op (0101, a=3, b=5) gives 0xFFFFFFFE with rsp_err=0.
- Reset asserted while S1 and S2 are both full -> rsp_valid=0 immediately; after release, requests 1 and 3 both valid -> 1 is granted first (ptr=0).
- With ALU_ARB_FLAGS_EN: op=0101, a=b=9 -> rsp_zero=1, rsp_neg=0; op=0011, a=0 -> rsp_data=0xFFFFFFFF, rsp_neg=1.
